// File: rtl/frogger_move_gen.sv
// Turns four bouncy direction switches into clean one-cycle movement strobes
// with press detection, auto-repeat and Up > Down > Left > Right priority.
module frogger_move_gen #(
  parameter int unsigned c_DEBOUNCE_LIMIT = 250000,
  parameter int unsigned c_REPEAT_DELAY   = 10000000,
  parameter int unsigned c_REPEAT_PERIOD  = 5000000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  input  logic i_Switch_3,
  input  logic i_Switch_4,
  input  logic i_Enable,
  output logic o_Up_Mvt,
  output logic o_Down_Mvt,
  output logic o_Left_Mvt,
  output logic o_Right_Mvt,
  output logic o_Held
);

  localparam int unsigned DB_W    = $clog2(c_DEBOUNCE_LIMIT);
  localparam int unsigned RPT_MAX = (c_REPEAT_DELAY > c_REPEAT_PERIOD) ? c_REPEAT_DELAY : c_REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(c_DEBOUNCE_LIMIT - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(c_REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(c_REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  // Internal direction vectors use bit 0 = Up, 1 = Down, 2 = Left, 3 = Right,
  // so the lowest set bit is always the highest-priority direction.
  logic [3:0] rawSw;
  logic [3:0] syncMeta_q;
  logic [3:0] syncOut_q;
  logic [3:0] debounced_q;
  logic [3:0] debouncedPrev_q;
  logic [DB_W-1:0] dbCnt_q [4];
  logic [3:0] press;
  logic [3:0] otherPress;

  state_t          state_q;
  logic [1:0]      dir_q;
  logic [RPT_W-1:0] cnt_q;
  logic [3:0]      strobe_q;
  logic            held_q;

  assign rawSw = {i_Switch_3, i_Switch_2, i_Switch_4, i_Switch_1};

  function automatic logic [1:0] pickDir(input logic [3:0] p);
    logic [1:0] d;
    d = 2'd3;
    if (p[2]) d = 2'd2;
    if (p[1]) d = 2'd1;
    if (p[0]) d = 2'd0;
    return d;
  endfunction

  function automatic logic [3:0] dirOneHot(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      syncMeta_q <= '0;
      syncOut_q  <= '0;
    end else begin
      syncMeta_q <= rawSw;
      syncOut_q  <= syncMeta_q;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      debounced_q     <= '0;
      debouncedPrev_q <= '0;
      for (int i = 0; i < 4; i++) dbCnt_q[i] <= '0;
    end else begin
      debouncedPrev_q <= debounced_q;
      for (int i = 0; i < 4; i++) begin
        if (syncOut_q[i] == debounced_q[i]) begin
          dbCnt_q[i] <= '0;
        end else if (dbCnt_q[i] == DB_LAST) begin
          debounced_q[i] <= syncOut_q[i];
          dbCnt_q[i]     <= '0;
        end else begin
          dbCnt_q[i] <= dbCnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign press      = debounced_q & ~debouncedPrev_q;
  assign otherPress = press & ~dirOneHot(dir_q);

  // Release beats preemption, and both beat a same-cycle repeat expiry, so at
  // most one strobe leaves per cycle.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= S_IDLE;
      dir_q    <= 2'd0;
      cnt_q    <= '0;
      strobe_q <= '0;
      held_q   <= 1'b0;
    end else begin
      strobe_q <= '0;
      held_q   <= 1'b0;
      if (!i_Enable) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (|press) begin
              strobe_q <= dirOneHot(pickDir(press));
              dir_q    <= pickDir(press);
              cnt_q    <= '0;
              state_q  <= S_DELAY;
              held_q   <= 1'b1;
            end
          end
          S_DELAY, S_REPEAT: begin
            if (!debounced_q[dir_q]) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
            end else if (|otherPress) begin
              strobe_q <= dirOneHot(pickDir(otherPress));
              dir_q    <= pickDir(otherPress);
              cnt_q    <= '0;
              state_q  <= S_DELAY;
              held_q   <= 1'b1;
            end else begin
              held_q <= 1'b1;
              if (cnt_q == ((state_q == S_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                strobe_q <= dirOneHot(dir_q);
                cnt_q    <= '0;
                state_q  <= S_REPEAT;
              end else begin
                cnt_q <= cnt_q + RPT_W'(1);
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign o_Up_Mvt    = strobe_q[0];
  assign o_Down_Mvt  = strobe_q[1];
  assign o_Left_Mvt  = strobe_q[2];
  assign o_Right_Mvt = strobe_q[3];
  assign o_Held      = held_q;

endmodule
